// File: rtl/video_timing_gen_pkg.sv
// Shared definitions for the raster timing generator.
//   - axis_timing_t / video_timing_t : one axis (act/fp/sw/bp) and a full mode
//   - preset modes: 720p60, 1080p60, 480p
//   - helpers for the axis total and the sync window bounds
// No ports; imported by vtg_axis_counter and video_timing_gen.
package video_timing_gen_pkg;

  typedef struct packed {
    logic [15:0] act;
    logic [15:0] fp;
    logic [15:0] sw;
    logic [15:0] bp;
  } axis_timing_t;

  typedef struct packed {
    axis_timing_t h;
    axis_timing_t v;
    logic         hpol;
    logic         vpol;
  } video_timing_t;

  localparam video_timing_t TIMING_720P60 = '{
    h: '{act: 16'd1280, fp: 16'd110, sw: 16'd40, bp: 16'd220},
    v: '{act: 16'd720,  fp: 16'd5,   sw: 16'd5,  bp: 16'd20},
    hpol: 1'b1, vpol: 1'b1};

  localparam video_timing_t TIMING_1080P60 = '{
    h: '{act: 16'd1920, fp: 16'd88, sw: 16'd44, bp: 16'd148},
    v: '{act: 16'd1080, fp: 16'd4,  sw: 16'd5,  bp: 16'd36},
    hpol: 1'b1, vpol: 1'b1};

  localparam video_timing_t TIMING_480P = '{
    h: '{act: 16'd720, fp: 16'd16, sw: 16'd62, bp: 16'd60},
    v: '{act: 16'd480, fp: 16'd9,  sw: 16'd6,  bp: 16'd30},
    hpol: 1'b0, vpol: 1'b0};

  // Clocks (or lines) per full period of one axis.
  function automatic int axis_total(int act, int fp, int sw, int bp);
    return act + fp + sw + bp;
  endfunction

  // First count inside the sync window.
  function automatic int sync_start(int act, int fp);
    return act + fp;
  endfunction

  // First count after the sync window.
  function automatic int sync_end(int act, int fp, int sw);
    return act + fp + sw;
  endfunction

endpackage

// File: rtl/vtg_axis_counter.sv
// One raster axis: a wrapping counter plus its active/sync decode.
//   clk   in   pixel clock
//   xres  in   synchronous active-low reset (counter -> 0)
//   clr   in   force counter to 0 (has priority over step)
//   step  in   advance by one
//   cnt   out  current count, 0..total-1
//   wrap  out  combinational: high at the last count while stepping
//   act   out  count lies in the active region
//   sync  out  sync level, already at the polarity given by p_pol
// The counter width must hold total-1 (total <= 2**p_width).
module vtg_axis_counter
  import video_timing_gen_pkg::*;
#(
  parameter int p_width = 11,
  parameter int p_act   = 1280,
  parameter int p_fp    = 110,
  parameter int p_sw    = 40,
  parameter int p_bp    = 220,
  parameter int p_pol   = 1
) (
  input  logic               clk,
  input  logic               xres,
  input  logic               clr,
  input  logic               step,
  output logic [p_width-1:0] cnt,
  output logic               wrap,
  output logic               act,
  output logic               sync
);

  localparam int TOTAL = axis_total(p_act, p_fp, p_sw, p_bp);
  localparam logic [p_width-1:0] LAST       = p_width'(TOTAL - 1);
  localparam logic [p_width-1:0] ACT_END    = p_width'(p_act);
  localparam logic [p_width-1:0] SYNC_FIRST = p_width'(sync_start(p_act, p_fp));
  localparam logic [p_width-1:0] SYNC_END   = p_width'(sync_end(p_act, p_fp, p_sw));
  localparam logic               POL        = 1'(p_pol);

  logic [p_width-1:0] cnt_q, cnt_d;

  assign wrap = step && (cnt_q == LAST);

  always_comb begin
    // NOTE: default assignment first, so every path drives cnt_d and no latch is inferred.
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (step) begin
      cnt_d = wrap ? '0 : cnt_q + p_width'(1);
    end
  end

  // NOTE: reset is sampled on the clock edge only (synchronous), and state
  // uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!xres) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign act  = (cnt_q < ACT_END);
  assign sync = ((cnt_q >= SYNC_FIRST) && (cnt_q < SYNC_END)) ? POL : ~POL;

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing source: DE/HSync/VSync plus pixel coordinates and a
// start-of-frame pulse, all registered and mutually cycle-aligned.
//   i_clk   in   pixel clock
//   i_xres  in   synchronous active-low reset
//   i_en    in   run enable; low forces the raster back to (0,0)
//   o_de    out  data enable
//   o_hs    out  hsync at polarity p_hpol
//   o_vs    out  vsync at polarity p_vpol
//   o_sof   out  one-clock pulse on the first active pixel of a frame
//   o_hcnt  out  active x coordinate (valid while o_de)
//   o_vcnt  out  active y coordinate (valid while o_de)
module video_timing_gen
  import video_timing_gen_pkg::*;
#(
  parameter int p_hcnt = 11,
  parameter int p_vcnt = 11,
  parameter int p_hact = 1280,
  parameter int p_hfp  = 110,
  parameter int p_hsw  = 40,
  parameter int p_hbp  = 220,
  parameter int p_vact = 720,
  parameter int p_vfp  = 5,
  parameter int p_vsw  = 5,
  parameter int p_vbp  = 20,
  parameter int p_hpol = 1,
  parameter int p_vpol = 1
) (
  input  logic              i_clk,
  input  logic              i_xres,
  input  logic              i_en,
  output logic              o_de,
  output logic              o_hs,
  output logic              o_vs,
  output logic              o_sof,
  output logic [p_hcnt-1:0] o_hcnt,
  output logic [p_vcnt-1:0] o_vcnt
);

  localparam logic HS_IDLE = ~1'(p_hpol);
  localparam logic VS_IDLE = ~1'(p_vpol);

  // run_q is i_en one clock late. The raster only moves (and the outputs only
  // decode it) once enable has been seen on two consecutive edges, so the edge
  // that first samples i_en high parks the counters at (0,0) and the next edge
  // presents that pixel with o_sof. It deliberately ignores reset: a reset
  // while enabled zeroes the counters and the frame restarts on the next clock.
  logic run_q, run_d;
  logic valid;

  logic [p_hcnt-1:0] h_cnt;
  logic [p_vcnt-1:0] v_cnt;
  logic h_wrap, h_act, h_sync;
  logic v_wrap_unused, v_act, v_sync;

  logic              de_q, de_d;
  logic              hs_q, hs_d;
  logic              vs_q, vs_d;
  logic              sof_q, sof_d;
  logic [p_hcnt-1:0] hcnt_q, hcnt_d;
  logic [p_vcnt-1:0] vcnt_q, vcnt_d;

  assign run_d = i_en;
  assign valid = run_q && i_en;

  vtg_axis_counter #(
    .p_width(p_hcnt), .p_act(p_hact), .p_fp(p_hfp),
    .p_sw(p_hsw), .p_bp(p_hbp), .p_pol(p_hpol)
  ) u_h (
    .clk (i_clk),
    .xres(i_xres),
    .clr (~i_en),
    .step(valid),
    .cnt (h_cnt),
    .wrap(h_wrap),
    .act (h_act),
    .sync(h_sync)
  );

  // Lines advance when the line counter wraps; the frame wrap itself is not
  // needed because o_sof is decoded directly from (0,0).
  vtg_axis_counter #(
    .p_width(p_vcnt), .p_act(p_vact), .p_fp(p_vfp),
    .p_sw(p_vsw), .p_bp(p_vbp), .p_pol(p_vpol)
  ) u_v (
    .clk (i_clk),
    .xres(i_xres),
    .clr (~i_en),
    .step(h_wrap),
    .cnt (v_cnt),
    .wrap(v_wrap_unused),
    .act (v_act),
    .sync(v_sync)
  );

  always_comb begin
    de_d   = 1'b0;
    hs_d   = HS_IDLE;
    vs_d   = VS_IDLE;
    sof_d  = 1'b0;
    hcnt_d = '0;
    vcnt_d = '0;
    if (valid) begin
      de_d   = h_act && v_act;
      hs_d   = h_sync;
      vs_d   = v_sync;
      sof_d  = (h_cnt == '0) && (v_cnt == '0);
      hcnt_d = h_cnt;
      vcnt_d = v_cnt;
    end
  end

  always_ff @(posedge i_clk) begin
    run_q <= run_d;
  end

  always_ff @(posedge i_clk) begin
    if (!i_xres) begin
      de_q   <= 1'b0;
      hs_q   <= HS_IDLE;
      vs_q   <= VS_IDLE;
      sof_q  <= 1'b0;
      hcnt_q <= '0;
      vcnt_q <= '0;
    end else begin
      de_q   <= de_d;
      hs_q   <= hs_d;
      vs_q   <= vs_d;
      sof_q  <= sof_d;
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
    end
  end

  assign o_de   = de_q;
  assign o_hs   = hs_q;
  assign o_vs   = vs_q;
  assign o_sof  = sof_q;
  assign o_hcnt = hcnt_q;
  assign o_vcnt = vcnt_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Self-checking bench for video_timing_gen on a tiny raster:
// 8 clocks per line (4 active, fp 1, sync 2, bp 1), 6 lines per frame
// (3 active, fp 1, sync 1, bp 1), both syncs active high.
module tb_video_timing_gen;

  localparam int HACT = 4, HFP = 1, HSW = 2, HBP = 1;
  localparam int VACT = 3, VFP = 1, VSW = 1, VBP = 1;
  localparam int HTOT  = HACT + HFP + HSW + HBP;
  localparam int VTOT  = VACT + VFP + VSW + VBP;
  localparam int FRAME = HTOT * VTOT;

  logic       clk = 1'b0;
  logic       i_xres = 1'b0;
  logic       i_en = 1'b0;
  logic       o_de, o_hs, o_vs, o_sof;
  logic [2:0] o_hcnt, o_vcnt;

  int n_checks = 0;
  int n_fail   = 0;

  video_timing_gen #(
    .p_hcnt(3), .p_vcnt(3),
    .p_hact(HACT), .p_hfp(HFP), .p_hsw(HSW), .p_hbp(HBP),
    .p_vact(VACT), .p_vfp(VFP), .p_vsw(VSW), .p_vbp(VBP),
    .p_hpol(1), .p_vpol(1)
  ) dut (
    .i_clk (clk),
    .i_xres(i_xres),
    .i_en  (i_en),
    .o_de  (o_de),
    .o_hs  (o_hs),
    .o_vs  (o_vs),
    .o_sof (o_sof),
    .o_hcnt(o_hcnt),
    .o_vcnt(o_vcnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, got, want, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // pos is the raster position (0..FRAME-1) the next running edge presents.
  // Outputs present pos only when enable was high on this edge and the
  // previous one; otherwise the raster restarts at 0 and outputs are idle.
  int pos = 0;
  bit prev_en = 1'b0;
  bit model_ok = 1'b0;
  bit exp_de, exp_hs, exp_vs, exp_sof;
  int exp_h, exp_v;

  always @(posedge clk) begin
    if (!i_xres || !(i_en && prev_en)) begin
      exp_de = 0; exp_hs = 0; exp_vs = 0; exp_sof = 0;
      exp_h = 0; exp_v = 0;
      pos = 0;
    end else begin
      exp_h   = pos % HTOT;
      exp_v   = pos / HTOT;
      exp_de  = (exp_h < HACT) && (exp_v < VACT);
      exp_hs  = (exp_h >= HACT + HFP) && (exp_h < HACT + HFP + HSW);
      exp_vs  = (exp_v >= VACT + VFP) && (exp_v < VACT + VFP + VSW);
      exp_sof = (pos == 0);
      pos = (pos + 1) % FRAME;
    end
    prev_en  = i_en;
    model_ok = 1'b1;
  end

  // ---------------- cycle compare ----------------
  always @(negedge clk) begin
    if (model_ok) begin
      check("de",  o_de,  exp_de);
      check("hs",  o_hs,  exp_hs);
      check("vs",  o_vs,  exp_vs);
      check("sof", o_sof, exp_sof);
      if (exp_de) begin
        check("hcnt", o_hcnt, exp_h);
        check("vcnt", o_vcnt, exp_v);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input bit en, input bit xres);
    i_en   = en;
    i_xres = xres;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int last_sof, sof_seen, de_cnt, vs_cnt, vs_first, w;

    // 1: reset, then idle with enable low for 100 clocks
    cyc(3);
    drive(0, 1);
    cyc(100);
    check("idle_de", o_de, 0);
    check("idle_hs", o_hs, 0);
    check("idle_vs", o_vs, 0);
    check("idle_sof", o_sof, 0);
    check("idle_hcnt", o_hcnt, 0);
    check("idle_vcnt", o_vcnt, 0);

    // 2: enable sampled at edge N
    drive(1, 1);
    cyc(1);                                   // after N
    check("en_n_sof", o_sof, 0);
    check("en_n_de", o_de, 0);
    cyc(1);                                   // after N+1
    check("en_n1_sof", o_sof, 1);
    check("en_n1_de", o_de, 1);
    check("en_n1_hcnt", o_hcnt, 0);
    check("en_n1_vcnt", o_vcnt, 0);
    for (int k = 1; k < 4; k++) begin         // N+2..N+4
      cyc(1);
      check("line0_de", o_de, 1);
      check("line0_hcnt", o_hcnt, k);
    end
    cyc(1);                                   // N+5: front porch
    check("fp_de", o_de, 0);
    check("fp_hs", o_hs, 0);
    cyc(1);                                   // N+6
    check("hs_n6", o_hs, 1);
    cyc(1);                                   // N+7
    check("hs_n7", o_hs, 1);
    cyc(1);                                   // N+8: back porch
    check("hs_n8", o_hs, 0);
    cyc(1);                                   // N+9: line 1 begins
    check("line1_de", o_de, 1);
    check("line1_hcnt", o_hcnt, 0);
    check("line1_vcnt", o_vcnt, 1);
    check("line1_sof", o_sof, 0);

    // 4: counters hold (h=2,v=1) after N+10; drop enable for edge N+11
    cyc(1);
    drive(0, 1);
    cyc(1);
    check("drop_de", o_de, 0);
    check("drop_hs", o_hs, 0);
    check("drop_vs", o_vs, 0);
    check("drop_sof", o_sof, 0);
    cyc(2);
    drive(1, 1);
    cyc(1);
    check("reen_first_sof", o_sof, 0);
    cyc(1);
    check("reen_sof", o_sof, 1);
    check("reen_hcnt", o_hcnt, 0);
    check("reen_vcnt", o_vcnt, 0);

    // 3: free run for three frames from this sof (t=0)
    last_sof = 0; sof_seen = 0; de_cnt = 0; vs_cnt = 0; vs_first = -1;
    for (int t = 0; t < 3 * FRAME; t++) begin
      if (t < FRAME) begin
        if (o_de) de_cnt++;
        if (o_vs) begin
          vs_cnt++;
          if (vs_first < 0) vs_first = t;
        end
      end
      if (o_sof && t > 0) begin
        check("sof_period", t - last_sof, FRAME);
        last_sof = t;
        sof_seen++;
      end
      cyc(1);
    end
    check("sof_count", sof_seen, 2);
    check("de_per_frame", de_cnt, 12);
    check("vs_clocks", vs_cnt, 8);
    // vsync is line 4: its first clock is 4 lines of 8 after the sof pixel
    check("vs_offset", vs_first, 32);

    // 5: one-clock reset in the middle of hsync while enabled
    w = 0;
    while (o_hs !== 1'b1 && w < 20) begin
      cyc(1);
      w++;
    end
    check("hs_found", o_hs, 1);
    drive(1, 0);
    cyc(1);
    check("rst_de", o_de, 0);
    check("rst_hs", o_hs, 0);
    check("rst_vs", o_vs, 0);
    check("rst_sof", o_sof, 0);
    check("rst_hcnt", o_hcnt, 0);
    check("rst_vcnt", o_vcnt, 0);
    drive(1, 1);
    cyc(1);
    check("rst_rel_sof", o_sof, 1);
    check("rst_rel_de", o_de, 1);

    // random enable / reset traffic, checked every clock by the model
    for (int s = 0; s < 40; s++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 9) != 0);
      cyc($urandom_range(1, 70));
    end
    drive(1, 1);
    cyc(2 * FRAME);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
